// File: rtl/scan_loader.sv
// Scan-chain loader: serialises program bytes into the memory_bank scan chain
// and reassembles the bits leaving the chain into bytes. Recirc mode dumps without destroying.
module scan_loader #(
    parameter int CHAIN_LEN = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       recirc,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       scan_enable,
    output logic       scan_in,
    input  logic       scan_out,
    output logic       busy,
    output logic       done
);

    localparam int              BYTES     = CHAIN_LEN / 8;
    localparam int              BCW       = $clog2(BYTES + 1);
    localparam logic [BCW-1:0]  LAST_BYTE = BCW'(BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        SHIFT,
        EMIT
    } state_t;

    state_t         state_q;
    logic           recirc_q;
    logic [2:0]     bit_cnt_q;
    logic [BCW-1:0] byte_cnt_q;
    logic [7:0]     tx_q;
    logic [7:0]     rx_q;
    logic [7:0]     out_data_q;
    logic           in_ready_q;
    logic           out_valid_q;
    logic           scan_enable_q;
    logic           busy_q;
    logic           done_q;

    logic [7:0]     rx_d;
    logic [7:0]     tx_d;
    logic [2:0]     bit_cnt_d;
    logic [BCW-1:0] byte_cnt_d;

    // scan_out is the chain's last bit before the edge; it enters rx at the LSB.
    assign rx_d       = {rx_q[6:0], scan_out};
    assign tx_d       = {tx_q[6:0], 1'b0};
    assign bit_cnt_d  = bit_cnt_q + 3'd1;
    assign byte_cnt_d = byte_cnt_q + BCW'(1);

    always_ff @(posedge clk) begin
        // NOTE: every state register uses <= so all of them see pre-edge values of each other.
        if (!rst) begin
            state_q       <= IDLE;
            recirc_q      <= 1'b0;
            bit_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            tx_q          <= '0;
            rx_q          <= '0;
            out_data_q    <= '0;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            scan_enable_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        recirc_q   <= recirc;
                        byte_cnt_q <= '0;
                        bit_cnt_q  <= '0;
                        busy_q     <= 1'b1;
                        if (recirc) begin
                            state_q       <= SHIFT;
                            scan_enable_q <= 1'b1;
                        end else begin
                            state_q    <= FETCH;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (in_valid && in_ready_q) begin
                        tx_q          <= in_data;
                        bit_cnt_q     <= '0;
                        in_ready_q    <= 1'b0;
                        scan_enable_q <= 1'b1;
                        state_q       <= SHIFT;
                    end
                end
                SHIFT: begin
                    tx_q      <= tx_d;
                    rx_q      <= rx_d;
                    bit_cnt_q <= bit_cnt_d;
                    if (bit_cnt_q == 3'd7) begin
                        out_data_q    <= rx_d;
                        out_valid_q   <= 1'b1;
                        scan_enable_q <= 1'b0;
                        state_q       <= EMIT;
                    end
                end
                EMIT: begin
                    // The chain is frozen here until the consumer takes the byte.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        byte_cnt_q  <= byte_cnt_d;
                        if (byte_cnt_q == LAST_BYTE) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else if (recirc_q) begin
                            state_q       <= SHIFT;
                            scan_enable_q <= 1'b1;
                        end else begin
                            state_q    <= FETCH;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign scan_enable = scan_enable_q;
    assign busy        = busy_q;
    assign done        = done_q;

    // Recirc feeds the chain's tail straight back to its head so a dump is non-destructive.
    assign scan_in = scan_enable_q & (recirc_q ? scan_out : tx_q[7]);

    a_handshake_exclusive: assert property (@(posedge clk) disable iff (!rst)
        !(in_ready_q && out_valid_q));
    a_byte_cnt_bound: assert property (@(posedge clk) disable iff (!rst)
        byte_cnt_q <= BCW'(BYTES));

endmodule

// File: tb/tb_scan_loader.sv
// Bench for scan_loader: a 256-bit behavioural chain plus a byte-level model of its
// contents (supply order) predicts every emitted byte across load, dump, stall and abort.
module tb_scan_loader;

    localparam int CHAIN_LEN = 256;
    localparam int BYTES     = CHAIN_LEN / 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       recirc;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       scan_enable;
    logic       scan_in;
    logic       scan_out;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    scan_loader #(.CHAIN_LEN(CHAIN_LEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .recirc      (recirc),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .scan_enable (scan_enable),
        .scan_in     (scan_in),
        .scan_out    (scan_out),
        .busy        (busy),
        .done        (done)
    );

    // Memory-bank stand-in: scan_in enters bit 0, bit CHAIN_LEN-1 is the far end.
    logic [CHAIN_LEN-1:0] chain;
    logic [CHAIN_LEN-1:0] preload_val;
    logic                 preload_en;

    assign scan_out = chain[CHAIN_LEN-1];

    always @(posedge clk) begin
        if (preload_en)       chain <= preload_val;
        else if (scan_enable) chain <= {chain[CHAIN_LEN-2:0], scan_in};
    end

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] model [BYTES];
    logic [7:0] seq   [BYTES];
    logic [7:0] rnd1  [BYTES];
    logic [7:0] rnd2  [BYTES];
    logic [7:0] rnd3  [BYTES];
    logic [7:0] got   [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] chain_byte(input int k);
        return chain[CHAIN_LEN-1-8*k -: 8];
    endfunction

    task automatic preload(input logic [7:0] b [BYTES]);
        @(negedge clk);
        for (int k = 0; k < BYTES; k++) preload_val[CHAIN_LEN-1-8*k -: 8] = b[k];
        preload_en = 1'b1;
        @(negedge clk);
        preload_en = 1'b0;
    endtask

    task automatic check_chain(input string name);
        for (int k = 0; k < BYTES; k++)
            check($sformatf("%s_chain%0d", name, k), chain_byte(k), model[k]);
    endtask

    task automatic check_idle_outputs(input string name);
        check({name, "_busy"},      busy,        1'b0);
        check({name, "_done"},      done,        1'b0);
        check({name, "_in_ready"},  in_ready,    1'b0);
        check({name, "_out_valid"}, out_valid,   1'b0);
        check({name, "_scan_en"},   scan_enable, 1'b0);
        check({name, "_scan_in"},   scan_in,     1'b0);
    endtask

    // NOTE: outputs are sampled and inputs driven on the falling edge, half a cycle from the DUT's edge.
    task automatic run_session(input logic rc, input logic [7:0] src [BYTES],
                               input logic [7:0] exp_out [BYTES],
                               input int stall_byte, input int stall_len,
                               input int bp_byte, input int bp_len,
                               input int abort_at, input int exp_cycles, input string name);
        int         idx     = 0;
        int         cyc     = 0;
        int         se_n    = 0;
        int         done_n  = 0;
        int         stall_n = 0;
        int         bp_n    = 0;
        logic [7:0] held    = '0;
        bit         fin     = 1'b0;
        bit         aborted = 1'b0;
        got.delete();
        @(negedge clk);
        start     = 1'b1;
        recirc    = rc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (!fin && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (in_ready && out_valid) check({name, "_ready_valid_overlap"}, 1'b1, 1'b0);
            if (done) begin
                done_n++;
                fin = 1'b1;
                check({name, "_busy_at_done"}, busy, 1'b0);
            end
            if (abort_at >= 0 && scan_enable && se_n == abort_at) begin
                rst     = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (scan_enable) se_n++;
            if (in_ready && idx == stall_byte && stall_n < stall_len) begin
                in_valid = 1'b0;
                stall_n++;
                check({name, "_stall_scan_en"}, scan_enable, 1'b0);
            end else begin
                in_valid = !rc && idx < BYTES;
                if (idx < BYTES) in_data = src[idx];
                if (in_valid && in_ready) idx++;
            end
            if (out_valid && got.size() == bp_byte && bp_n < bp_len) begin
                if (bp_n == 0) held = out_data;
                out_ready = 1'b0;
                bp_n++;
                check({name, "_bp_scan_en"}, scan_enable, 1'b0);
                check({name, "_bp_out_data"}, out_data, held);
            end else begin
                out_ready = 1'b1;
                if (out_valid) got.push_back(out_data);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (aborted) begin
            @(negedge clk);
            rst = 1'b1;
            check_idle_outputs({name, "_abort"});
            repeat (3) begin
                @(negedge clk);
                if (done) done_n++;
            end
            check({name, "_abort_no_done"}, done_n, 0);
            check({name, "_abort_busy"}, busy, 1'b0);
        end else begin
            check({name, "_finished"}, fin, 1'b1);
            check({name, "_done_pulses"}, done_n, 1);
            check({name, "_scan_cycles"}, se_n, CHAIN_LEN);
            if (exp_cycles > 0) check({name, "_cycles"}, cyc, exp_cycles);
            if (stall_len > 0) check({name, "_stall_len"}, stall_n, stall_len);
            if (bp_len > 0) check({name, "_bp_len"}, bp_n, bp_len);
            check({name, "_out_count"}, got.size(), BYTES);
            for (int k = 0; k < BYTES && k < got.size(); k++)
                check($sformatf("%s_out%0d", name, k), got[k], exp_out[k]);
            @(negedge clk);
            check({name, "_done_single"}, done, 1'b0);
            check({name, "_idle_busy"}, busy, 1'b0);
        end
    endtask

    initial begin
        rst        = 1'b0;
        start      = 1'b0;
        recirc     = 1'b0;
        in_data    = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        preload_en = 1'b0;
        preload_val = '0;
        for (int k = 0; k < BYTES; k++) begin
            seq[k]   = 8'(k);
            rnd1[k]  = 8'($urandom);
            rnd2[k]  = 8'($urandom);
            rnd3[k]  = 8'($urandom);
            model[k] = 8'($urandom);
        end

        // Reset holds everything low; a start during reset is ignored.
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_out_data", out_data, 8'h00);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("reset_start_busy", busy, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("post_reset");

        // Load 0x00..0x1F over random prior contents, which must come back out.
        preload(model);
        run_session(1'b0, seq, model, -1, 0, -1, 0, -1, 1 + 10 * BYTES, "load_seq");
        model = seq;
        check_chain("load_seq");
        check("far_end_bit", chain[CHAIN_LEN-1], seq[0][7]);

        run_session(1'b1, seq, model, -1, 0, -1, 0, -1, 1 + 9 * BYTES, "dump1");
        check_chain("dump1");
        run_session(1'b1, seq, model, -1, 0, -1, 0, -1, 1 + 9 * BYTES, "dump2");
        check_chain("dump2");

        // Consumer stall after three bytes of a dump.
        run_session(1'b1, seq, model, -1, 0, 3, 20, -1, 0, "dump_bp");
        check_chain("dump_bp");

        // Producer stall mid-load, then dump the new contents.
        run_session(1'b0, rnd1, model, 12, 15, -1, 0, -1, 0, "load_stall");
        model = rnd1;
        check_chain("load_stall");
        run_session(1'b1, rnd1, model, -1, 0, -1, 0, -1, 0, "dump_rnd1");

        // Abort at bit 4 of byte 10; the chain keeps its partial contents.
        run_session(1'b0, rnd2, model, -1, 0, -1, 0, 10 * 8 + 4, 0, "abort");
        for (int k = 0; k < BYTES; k++) model[k] = chain_byte(k);
        run_session(1'b0, rnd3, model, -1, 0, -1, 0, -1, 1 + 10 * BYTES, "after_abort");
        model = rnd3;
        check_chain("after_abort");
        run_session(1'b1, rnd3, model, -1, 0, -1, 0, -1, 0, "dump_rnd3");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
